// File: rtl/timer_dev_pkg.sv
// Shared definitions for the memory-mapped down-counter timer: register map,
// CTRL field positions, mode encodings and FSM state encoding.
package timer_dev_pkg;

    // Word offsets (byte address bits [3:2])
    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrPreset = 2'd1;
    localparam logic [1:0] AddrCount  = 2'd2;

    // CTRL field positions
    localparam int unsigned CtrlEnBit   = 0;
    localparam int unsigned CtrlModeLsb = 1;
    localparam int unsigned CtrlModeMsb = 2;
    localparam int unsigned CtrlImBit   = 3;

    // MODE encodings; anything other than auto-reload behaves as one-shot
    localparam logic [1:0] ModeOneShot = 2'b00;
    localparam logic [1:0] ModeReload  = 2'b01;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2,
        StInt  = 2'd3
    } state_e;

    // Pack the CTRL fields into the 32-bit read word
    function automatic logic [31:0] pack_ctrl(input logic en, input logic [1:0] mode,
                                              input logic im);
        logic [31:0] w;
        w                          = '0;
        w[CtrlEnBit]               = en;
        w[CtrlModeMsb:CtrlModeLsb] = mode;
        w[CtrlImBit]               = im;
        return w;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// Programmable down-counter timer on the CPU data-memory bus. Word-addressed
// CTRL/PRESET/COUNT registers, four-state load/count FSM and a level irq.
module timer_dev
    import timer_dev_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic        r_pend;
    logic [31:0] r_preset;
    logic [31:0] r_count;

    logic        w_en_nxt;
    logic [1:0]  w_mode_nxt;
    logic        w_im_nxt;
    logic        w_pend_nxt;
    logic [31:0] w_preset_nxt;
    logic [31:0] w_count_nxt;

    logic        w_ctrl_wr;
    logic        w_preset_wr;
    logic        w_reload;

    assign w_ctrl_wr   = we && (addr == AddrCtrl);
    assign w_preset_wr = we && (addr == AddrPreset);
    assign w_reload    = (r_mode == ModeReload);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (r_en) begin
                    w_state_nxt = StLoad;
                end
            end
            StLoad: begin
                w_state_nxt = r_en ? StCnt : StIdle;
            end
            StCnt: begin
                if (!r_en) begin
                    w_state_nxt = StIdle;
                end else if (r_count <= 32'd1) begin
                    w_state_nxt = StInt;
                end
            end
            StInt: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // FSM outputs: next values of the counter and CTRL/PEND registers
    always_comb begin
        w_en_nxt     = r_en;
        w_mode_nxt   = r_mode;
        w_im_nxt     = r_im;
        w_pend_nxt   = r_pend;
        w_preset_nxt = r_preset;
        w_count_nxt  = r_count;

        if (w_preset_wr) begin
            w_preset_nxt = wdata;
        end

        unique case (r_state)
            StLoad: begin
                w_count_nxt = r_preset;
            end
            StCnt: begin
                // Freeze when disabled; never decrement below zero
                if (r_en && (r_count != 32'd0)) begin
                    w_count_nxt = r_count - 32'd1;
                end
            end
            StInt: begin
                if (w_reload) begin
                    // Auto-reload: pending only lives for the INT cycle
                    w_pend_nxt = 1'b0;
                end else begin
                    w_en_nxt = 1'b0;
                end
            end
            default: begin
            end
        endcase

        // Pending is raised on the edge that enters INT so irq is registered
        if ((w_state_nxt == StInt) && (r_state != StInt)) begin
            w_pend_nxt = 1'b1;
        end

        // A CTRL write overrides every automatic update and acknowledges pending
        if (w_ctrl_wr) begin
            w_en_nxt   = wdata[CtrlEnBit];
            w_mode_nxt = wdata[CtrlModeMsb:CtrlModeLsb];
            w_im_nxt   = wdata[CtrlImBit];
            w_pend_nxt = 1'b0;
        end
    end

    // Register file and counter update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en     <= 1'b0;
            r_mode   <= ModeOneShot;
            r_im     <= 1'b0;
            r_pend   <= 1'b0;
            r_preset <= '0;
            r_count  <= '0;
        end else begin
            r_en     <= w_en_nxt;
            r_mode   <= w_mode_nxt;
            r_im     <= w_im_nxt;
            r_pend   <= w_pend_nxt;
            r_preset <= w_preset_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Zero-latency read mux
    always_comb begin
        rdata = '0;
        unique case (addr)
            AddrCtrl:   rdata = pack_ctrl(r_en, r_mode, r_im);
            AddrPreset: rdata = r_preset;
            AddrCount:  rdata = r_count;
            default:    rdata = '0;
        endcase
    end

    assign irq = r_pend && r_im;

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: expectations are queued alongside the
// stimulus and popped in order as the DUT outputs are sampled.
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    timer_dev u_dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    // An empty queue yields an unmatchable expectation so it shows up as a failure
    task automatic pop_exp(output exp_t e);
        if (sb_q.size() == 0) begin
            e.tag = "sb_underflow";
            e.val = 'x;
        end else begin
            e = sb_q.pop_front();
        end
    endtask

    task automatic pop_rd(input logic [1:0] a);
        exp_t e;
        addr = a;
        we   = 1'b0;
        #1;
        pop_exp(e);
        check(e.tag, rdata, e.val);
    endtask

    task automatic pop_irq();
        exp_t e;
        #1;
        pop_exp(e);
        check(e.tag, {31'd0, irq}, e.val);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int pulses;

        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = '0;
        tick(2);
        reset = 1'b0;

        // Reset state
        push("rst_ctrl", 32'd0);
        push("rst_preset", 32'd0);
        push("rst_count", 32'd0);
        push("rst_irq", 32'd0);
        pop_rd(2'd0);
        pop_rd(2'd1);
        pop_rd(2'd2);
        pop_irq();

        // One-shot, PRESET=5, IM=1
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);                 // edge N
        push("os_count_n2", 32'd5);
        push("os_count_n6", 32'd1);
        push("os_irq_n6", 32'd0);
        push("os_count_n7", 32'd0);
        push("os_irq_n7", 32'd1);
        push("os_ctrl_n8", 32'h8);
        push("os_irq_n8", 32'd1);
        tick(2);
        pop_rd(2'd2);
        tick(4);
        pop_rd(2'd2);
        pop_irq();
        tick(1);
        pop_rd(2'd2);
        pop_irq();
        tick(1);
        pop_rd(2'd0);
        pop_irq();
        tick(3);
        push("os_irq_held", 32'd1);
        pop_irq();
        push("os_ack_irq", 32'd0);
        push("os_ack_ctrl", 32'd0);
        wr(2'd0, 32'd0);
        pop_irq();
        pop_rd(2'd0);

        // Auto-reload, PRESET=3: pulse every 6 cycles
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);                 // edge N
        for (int k = 1; k <= 18; k++) begin
            push($sformatf("ar_irq_n%0d", k), ((k == 5) || (k == 11) || (k == 17)) ? 32'd1 : 32'd0);
        end
        pulses = 0;
        for (int k = 1; k <= 18; k++) begin
            tick(1);
            pop_irq();
            if (irq) pulses++;
        end
        check("ar_pulses", pulses, 32'd3);
        push("ar_ctrl", 32'hB);
        pop_rd(2'd0);
        wr(2'd0, 32'd0);
        tick(2);

        // Masked one-shot, PRESET=10: irq never rises
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);                 // edge N
        for (int k = 1; k <= 14; k++) begin
            push($sformatf("mk_irq_n%0d", k), 32'd0);
        end
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            pop_irq();
        end
        push("mk_count", 32'd0);
        push("mk_ctrl", 32'd0);
        pop_rd(2'd2);
        pop_rd(2'd0);
        push("mk_ack_irq", 32'd0);
        push("mk_ack_ctrl", 32'h8);
        wr(2'd0, 32'h8);
        pop_irq();
        pop_rd(2'd0);
        wr(2'd0, 32'd0);

        // Freeze mid-count, PRESET write during CNT, COUNT write ignored
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);                 // edge N
        tick(2);
        push("fz_count_n2", 32'd10);
        pop_rd(2'd2);
        wr(2'd1, 32'd100);               // edge N+3
        push("fz_count_n3", 32'd9);
        push("fz_preset", 32'd100);
        pop_rd(2'd2);
        pop_rd(2'd1);
        tick(5);
        push("fz_count_n8", 32'd4);
        pop_rd(2'd2);
        wr(2'd0, 32'd0);                 // edge N+9
        push("fz_count_n9", 32'd3);
        push("fz_ctrl", 32'd0);
        pop_rd(2'd2);
        pop_rd(2'd0);
        tick(4);
        push("fz_count_held", 32'd3);
        pop_rd(2'd2);
        wr(2'd2, 32'd99);
        push("fz_count_ro", 32'd3);
        push("fz_irq", 32'd0);
        pop_rd(2'd2);
        pop_irq();
        wr(2'd0, 32'h1);
        tick(2);
        push("fz_reload_new_preset", 32'd100);
        pop_rd(2'd2);
        wr(2'd0, 32'd0);
        tick(2);

        // Asynchronous reset mid-count
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);                 // edge N
        tick(5);
        push("ar_count_pre", 32'd7);
        pop_rd(2'd2);
        reset = 1'b1;
        push("rs_count", 32'd0);
        push("rs_ctrl", 32'd0);
        push("rs_preset", 32'd0);
        push("rs_irq", 32'd0);
        pop_rd(2'd2);
        pop_rd(2'd0);
        pop_rd(2'd1);
        pop_irq();
        tick(1);
        reset = 1'b0;
        push("rs_irq_rel", 32'd0);
        pop_irq();

        // PRESET=0 after reset: INT three edges after enable
        wr(2'd0, 32'h9);                 // edge N
        push("p0_irq_n1", 32'd0);
        push("p0_irq_n2", 32'd0);
        push("p0_irq_n3", 32'd1);
        tick(1);
        pop_irq();
        tick(1);
        pop_irq();
        tick(1);
        pop_irq();
        push("p0_ack_irq", 32'd0);
        wr(2'd0, 32'd0);
        pop_irq();

        check("sb_drain", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped programmable down-counter timer acting as a responder on the CPU data-memory bus. The pipelined MIPS core issues word loads/stores to it exactly as it does to DM; the timer decodes the word offset, updates its registers, and raises a level interrupt request when a programmed count expires. It sits beside DM behind the address decode in the top level.

## Interface
- No parameters; register map and widths are fixed.
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- addr  in  2  word offset (byte address bits [3:2]); 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- we  in  1  write strobe, sampled on rising clk edge
- wdata  in  32  store data
- rdata  out  32  combinational read data for addr
- irq  out  1  interrupt request, level, registered state only

## Operation
- CTRL (rw): bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask, 1=enabled); bits[31:4] read 0, writes ignored.
- PRESET (rw, 32 bit): reload value. COUNT (ro): current count; writes ignored. addr 3 reads 0, writes ignored.
- Internal pending flag PEND; irq = PEND & IM.
- State machine IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 -> LOAD; else stay.
  - LOAD: COUNT<=PRESET; -> CNT (EN=0 -> IDLE, COUNT still loaded).
  - CNT: EN=0 -> IDLE, COUNT frozen. COUNT>=2 -> COUNT-1, stay. COUNT==1 -> COUNT<=0, -> INT. COUNT==0 -> INT.
  - INT: PEND<=1 on entry. Mode 00: EN<=0, -> IDLE. Mode 01: -> IDLE (EN stays 1, reload follows); PEND cleared on leaving INT, so mode-01 irq is a one-cycle pulse.
- Mode 00 PEND held until any CTRL write; CTRL write clears PEND.
- Writes to PRESET during CNT do not disturb COUNT; take effect at next LOAD.
- Simultaneous CTRL write and INT auto-clear of EN: write value wins for all CTRL bits; PEND cleared.
- Decrement is plain unsigned 32-bit; no underflow past 0 by construction.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, PEND=0, state IDLE, irq=0, rdata=0 (addr 0).
- Reset mid-count: asynchronous return to reset values; no irq glitch after deassertion.
- Register writes visible on rdata the cycle after the write edge.
- EN written at edge N: LOAD after N+1, COUNT=P and CNT after N+2, COUNT=0 and INT after N+2+P (P>=1), irq high during cycle after edge N+2+P. P=0: INT after N+3.
- Mode 00: EN reads 0 after edge N+3+P; irq stays high until CTRL write.
- Mode 01: period P+3 cycles (INT, IDLE, LOAD overhead); irq high one cycle per period.
- rdata purely combinational from addr and registers; zero latency.

## Structure
- Shared package: address offsets (CTRL/PRESET/COUNT), CTRL bit positions, MODE encodings, state encoding (2 bits).
- Single module; no sub-module warranted (counter and FSM tightly coupled).

## Test plan
- Reset then read addr 0/1/2 -> rdata 0,0,0; irq=0.
- PRESET=5, CTRL=0x9 (EN,mode00,IM) at edge N -> COUNT reads 5 after N+2, 0 after N+7, irq=1 from N+7, CTRL reads 0x8; write CTRL=0 -> irq=0 next cycle.
- PRESET=3, CTRL=0xB (mode01,IM) -> irq single-cycle pulses every 6 cycles, EN stays 1, three pulses observed in 18 cycles.
- PRESET=10, CTRL=0x1 (IM=0) -> COUNT reaches 0, irq stays 0, PEND visible by later CTRL=0x8 write clearing it (irq still 0).
- During CNT at COUNT=4 write CTRL=0 -> COUNT frozen at 3 next read, state IDLE; write COUNT=99 -> ignored.
- Assert reset with COUNT=7 mid-count -> all registers 0, irq 0 same cycle; PRESET=0, EN=1 after release -> INT after 3 edges.
